seq_decoder: RTL

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder.sv | 80 ++++++++
 1 files changed

// File: rtl/seq_decoder.sv
// seq_decoder: handshaked index register with rotate ops, decoded to one-hot or thermometer output.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_op/in_sel request side;
//        out_valid/out_ready beat handshake; O decoded output, idx current index, wrap rotate-wrap flag.
module seq_decoder #(
  parameter int SEL_W  = 4,
  parameter int THERMO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [SEL_W-1:0]      in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   O,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);
  localparam int OUT_W = 2**SEL_W;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t st_q, st_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] o_q, o_d;
  logic wrap_q, wrap_d, vld_q, vld_d, acc, act;
  assign in_ready  = !vld_q || out_ready;
  assign out_valid = vld_q;
  assign O         = o_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;
  assign acc       = in_valid && in_ready;
  assign act       = st_q == ACTIVE;
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    wrap_d = wrap_q;
    if (acc) begin
      case (in_op)
        2'b00: begin
          st_d   = ACTIVE;
          idx_d  = in_sel;
          wrap_d = 1'b0;
        end
        2'b01: begin
          st_d   = ACTIVE;
          idx_d  = act ? idx_q + SEL_W'(1) : '0;
          wrap_d = act && &idx_q;
        end
        2'b10: begin
          st_d   = ACTIVE;
          idx_d  = act ? idx_q - SEL_W'(1) : '1;
          wrap_d = act && ~|idx_q;
        end
        default: begin
          st_d   = IDLE;
          idx_d  = '0;
          wrap_d = 1'b0;
        end
      endcase
    end
    vld_d = acc || (vld_q && !out_ready);
    // ~idx_d equals OUT_W-1-idx_d, so the right shift leaves bits 0..idx_d set
    o_d = st_d == IDLE ? '0 : THERMO != 0 ? {OUT_W{1'b1}} >> ~idx_d : OUT_W'(1) << idx_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      idx_q  <= '0;
      o_q    <= '0;
      wrap_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      o_q    <= o_d;
      wrap_q <= wrap_d;
      vld_q  <= vld_d;
    end
  end
endmodule
